universal_shift_register: RTL and testbench

Parametrised WIDTH-bit register with a synchronous clock enable, eight operating modes (hold, load, logical/arithmetic shift, rotate, clear) and a multi-step shift engine. The engine performs an N-position shift one bit per clock under a Start/Busy/Done handshake. It generalises the single-bit enabled D flip-flop into the team's general-purpose datapath register. Typical uses are shift-and-add multipliers, serial links and barrel-shift-free ALU shifts.

---
 rtl/universal_shift_register.sv | 127 ++++++++++++
 tb/tb_universal_shift_register.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/universal_shift_register.sv
// WIDTH-bit datapath register with eight step modes and a multi-step shift
// engine driven by a start/busy/done handshake.
module universal_shift_register #(
  parameter int WIDTH        = 8,
  parameter int AMOUNT_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [2:0]              mode,
  input  logic [WIDTH-1:0]        d,
  input  logic                    serial_in,
  input  logic                    start,
  input  logic [AMOUNT_WIDTH-1:0] amount,
  output logic [WIDTH-1:0]        q,
  output logic                    serial_out,
  output logic                    busy,
  output logic                    done,
  output logic                    fsm_state
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  localparam logic [AMOUNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [AMOUNT_WIDTH-1:0] CNT_ONE  = {{(AMOUNT_WIDTH-1){1'b0}}, 1'b1};

  // Handshake: start is sampled on an enabled edge while idle; busy is high
  // for exactly the edges that still owe a step; done pulses one cycle after
  // the final step (or after an immediate zero-length / non-shift start).

  logic                    state;
  logic [AMOUNT_WIDTH-1:0] cnt;
  logic [2:0]              lmode;
  logic [WIDTH-1:0]        q_r;
  logic                    so_r;
  logic                    done_r;

  logic                    start_is_shift;
  logic [WIDTH:0]          idle_step;
  logic [WIDTH:0]          shift_step;

  // Returns {serial_out_next, q_next} for one application of m to cur.
  function automatic logic [WIDTH:0] step_fn(
    input logic [2:0]       m,
    input logic [WIDTH-1:0] cur,
    input logic             si,
    input logic             so,
    input logic [WIDTH-1:0] dd
  );
    logic [WIDTH:0] r;
    r = {so, cur};
    case (m)
      M_HOLD: r = {so, cur};
      M_LOAD: r = {so, dd};
      M_SHL:  r = {cur[WIDTH-1], cur[WIDTH-2:0], si};
      M_SHR:  r = {cur[0], si, cur[WIDTH-1:1]};
      M_ROL:  r = {cur[WIDTH-1], cur[WIDTH-2:0], cur[WIDTH-1]};
      M_ROR:  r = {cur[0], cur[0], cur[WIDTH-1:1]};
      M_ASR:  r = {cur[0], cur[WIDTH-1], cur[WIDTH-1:1]};
      M_CLR:  r = {so, {WIDTH{1'b0}}};
      default: r = {so, cur};
    endcase
    return r;
  endfunction

  always_comb begin
    start_is_shift = 1'b0;
    if (mode >= M_SHL && mode <= M_ASR) start_is_shift = 1'b1;
    idle_step  = step_fn(mode,  q_r, serial_in, so_r, d);
    shift_step = step_fn(lmode, q_r, serial_in, so_r, d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= CNT_ZERO;
      lmode  <= M_HOLD;
      q_r    <= '0;
      so_r   <= 1'b0;
      done_r <= 1'b0;
    end else begin
      // done is a pure one-cycle pulse, so it clears even on a gated edge
      done_r <= 1'b0;
      if (enable) begin
        case (state)
          ST_IDLE: begin
            if (start && start_is_shift && amount != CNT_ZERO) begin
              state <= ST_SHIFT;
              lmode <= mode;
              cnt   <= amount;
            end else begin
              // a zero-length shift start performs no step but still completes
              if (!(start && start_is_shift)) {so_r, q_r} <= idle_step;
              if (start) done_r <= 1'b1;
            end
          end
          ST_SHIFT: begin
            {so_r, q_r} <= shift_step;
            cnt         <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              state  <= ST_IDLE;
              done_r <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign q          = q_r;
  assign serial_out = so_r;
  assign busy       = (state == ST_SHIFT);
  assign done       = done_r;
  assign fsm_state  = state;

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed plus randomized bench for universal_shift_register, checked
// against an arithmetic reference model of the register's step rules.
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int AW = 4;

  logic          clk;
  logic          reset;
  logic          enable;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          serial_in;
  logic          start;
  logic [AW-1:0] amount;
  logic [W-1:0]  q;
  logic          serial_out;
  logic          busy;
  logic          done;
  logic          fsm_state;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;

  logic [W-1:0] exp_q[$];

  // reference model state
  int m_q, m_so, m_busy, m_done, m_cnt, m_mode;

  universal_shift_register #(.WIDTH(W), .AMOUNT_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .d(d),
    .serial_in(serial_in), .start(start), .amount(amount), .q(q),
    .serial_out(serial_out), .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one step of mode md applied to the model with plain arithmetic
  task automatic apply(input int md);
    int full, half, msb, lsb;
    full = 1 << W;
    half = 1 << (W - 1);
    msb  = m_q / half;
    lsb  = m_q % 2;
    case (md)
      1: m_q = int'(d);
      2: begin m_so = msb; m_q = (m_q * 2) % full + int'(serial_in); end
      3: begin m_so = lsb; m_q = m_q / 2 + int'(serial_in) * half; end
      4: begin m_so = msb; m_q = (m_q * 2) % full + msb; end
      5: begin m_so = lsb; m_q = m_q / 2 + lsb * half; end
      6: begin m_so = lsb; m_q = m_q / 2 + msb * half; end
      7: m_q = 0;
      default: ;
    endcase
  endtask

  task automatic model_edge();
    int md;
    md = int'(mode);
    if (reset) begin
      m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_mode = 0;
      return;
    end
    m_done = 0;
    if (!enable) return;
    if (m_busy != 0) begin
      apply(m_mode);
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin m_busy = 0; m_done = 1; end
    end else if (start && md >= 2 && md <= 6) begin
      if (amount != 0) begin
        m_busy = 1; m_cnt = int'(amount); m_mode = md;
      end else m_done = 1;
    end else begin
      apply(md);
      if (start) m_done = 1;
    end
  endtask

  // driver: advance one edge, then score all outputs against the model
  task automatic cycle();
    model_edge();
    exp_q.push_back(W'(m_q));
    @(posedge clk);
    #1;
    chk("q", int'(q), int'(exp_q.pop_front()));
    chk("serial_out", int'(serial_out), m_so);
    chk("busy", int'(busy), m_busy);
    chk("done", int'(done), m_done);
    chk("fsm_state", int'(fsm_state), m_busy);
  endtask

  task automatic load(input logic [W-1:0] val);
    mode = 3'b001; d = val; start = 1'b0; enable = 1'b1;
    cycle();
  endtask

  initial begin
    int edges;
    int done_seen;
    reset = 1'b1; enable = 1'b0; mode = 3'b000; d = '0;
    serial_in = 1'b0; start = 1'b0; amount = '0;
    m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_cnt = 0; m_mode = 0;

    // reset then load
    cycle(); cycle();
    chk("reset_q", int'(q), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    reset = 1'b0;
    load(8'hA5);
    chk("load_a5", int'(q), 8'hA5);

    // enable gating
    mode = 3'b111; enable = 1'b0;
    repeat (3) cycle();
    chk("gated_hold", int'(q), 8'hA5);
    enable = 1'b1;
    cycle();
    chk("clear", int'(q), 0);

    // single-step modes from 0x81
    load(8'h81); serial_in = 1'b0; mode = 3'b010; cycle();
    chk("shl_q", int'(q), 8'h02);
    chk("shl_so", int'(serial_out), 1);
    load(8'h81); mode = 3'b101; cycle();
    chk("ror_q", int'(q), 8'hC0);
    chk("ror_so", int'(serial_out), 1);
    load(8'h81); mode = 3'b110; cycle();
    chk("asr_q", int'(q), 8'hC0);

    // multi-step rotate by 3
    load(8'h01);
    mode = 3'b100; start = 1'b1; amount = 4'd3;
    cycle();
    chk("rot_busy0", int'(busy), 1);
    start = 1'b0; mode = 3'b111;
    cycle(); cycle();
    chk("rot_busy2", int'(busy), 1);
    cycle();
    chk("rot_q", int'(q), 8'h08);
    chk("rot_done", int'(done), 1);
    cycle();
    chk("rot_done_clr", int'(done), 0);

    // pause and overflow: 10-step shift with 2 gated cycles
    load(8'hFF);
    mode = 3'b010; serial_in = 1'b0; start = 1'b1; amount = 4'd10;
    cycle();
    start = 1'b0;
    edges = 1;
    while (!done && edges < 30) begin
      enable = (edges == 4 || edges == 5) ? 1'b0 : 1'b1;
      cycle();
      edges++;
    end
    enable = 1'b1;
    chk("pause_latency", edges, 13);
    chk("pause_q", int'(q), 0);

    // zero-amount start completes at once without touching q
    load(8'h3C);
    mode = 3'b011; start = 1'b1; amount = 4'd0;
    cycle();
    chk("zero_done", int'(done), 1);
    chk("zero_q", int'(q), 8'h3C);
    start = 1'b0;

    // back-to-back start in the done cycle
    mode = 3'b101; start = 1'b1; amount = 4'd1;
    cycle();
    chk("b2b_busy", int'(busy), 1);
    start = 1'b0;
    cycle();
    chk("b2b_q", int'(q), 8'h1E);

    // reset mid-run aborts without a done pulse
    load(8'h5A);
    mode = 3'b010; serial_in = 1'b1; start = 1'b1; amount = 4'd5;
    cycle();
    start = 1'b0;
    cycle(); cycle();
    reset = 1'b1;
    cycle();
    chk("abort_q", int'(q), 0);
    chk("abort_busy", int'(busy), 0);
    reset = 1'b0; mode = 3'b000;
    done_seen = 0;
    repeat (8) begin
      cycle();
      if (done) done_seen = 1;
    end
    chk("abort_no_done", done_seen, 0);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 60) == 0);
      enable    = ($urandom_range(0, 9) < 8);
      start     = ($urandom_range(0, 4) == 0);
      mode      = 3'($urandom_range(0, 7));
      amount    = AW'($urandom_range(0, (1 << AW) - 1));
      d         = W'($urandom_range(0, (1 << W) - 1));
      serial_in = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
